// File: rtl/bomb_center_controller.sv
// Top-level game sequencer for the bomb board.
// Broadcasts the round state and seed to every puzzle module, handshakes
// activation, counts strikes, tracks solved modules and runs the countdown.
// Everything the outside world sees comes straight from a register.

module bomb_center_controller #(
    parameter int N_MOD       = 4,
    parameter int MAX_STRIKES = 3,
    parameter int TICK_DIV    = 50000000,
    parameter int TIME_SEC    = 300,
    parameter int ACT_TIMEOUT = 1024,
    parameter int DET_CYCLES  = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      rnd_in,
    input  logic [N_MOD-1:0] mod_activated,
    input  logic [N_MOD-1:0] mod_failed,
    input  logic [N_MOD-1:0] mod_solved,
    output logic [2:0]       current_state,
    output logic [31:0]      rnd,
    output logic [2:0]       strikes,
    output logic [9:0]       time_left,
    output logic             strike_pulse,
    output logic             act_fault
);

    typedef enum logic [2:0] {
        IDLE              = 3'd0,
        ACTIVATING        = 3'd1,
        ACTIVATED         = 3'd2,
        DETONATING        = 3'd3,
        MISSION_FAILED    = 3'd4,
        MISSION_SUCCESSED = 3'd5
    } state_t;

    // Counter widths never drop to zero, even for degenerate parameter values.
    localparam int PW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
    localparam int AW = (ACT_TIMEOUT > 1) ? $clog2(ACT_TIMEOUT) : 1;
    localparam int DW = (DET_CYCLES > 1)  ? $clog2(DET_CYCLES)  : 1;

    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ACT_LAST     = AW'(ACT_TIMEOUT - 1);
    localparam logic [DW-1:0] DET_LAST     = DW'(DET_CYCLES - 1);
    localparam logic [9:0]    TIME_INIT    = 10'(TIME_SEC);
    localparam logic [2:0]    STRIKE_MAX   = 3'(MAX_STRIKES);
    localparam logic [7:0]    STRIKE_MAX_W = 8'(MAX_STRIKES);

    state_t            state_q,   state_d;
    logic              start_q;
    logic [31:0]       rnd_q,     rnd_d;
    logic [2:0]        strikes_q, strikes_d;
    logic [9:0]        timeLeft_q, timeLeft_d;
    logic              pulse_q,   pulse_d;
    logic              fault_q,   fault_d;
    logic [PW-1:0]     presc_q,   presc_d;
    logic [AW-1:0]     actCnt_q,  actCnt_d;
    logic [DW-1:0]     detCnt_q,  detCnt_d;
    logic [N_MOD-1:0]  solved_q,  solved_d;

    logic              startRise;
    logic [7:0]        newStrikes;
    logic [7:0]        strikeSum;

    // Only the rising edge of the (already debounced) start button matters.
    assign startRise = start & ~start_q;

    // Number of strikes reported this cycle and the unsaturated running total;
    // the total is compared before clamping so over-shoot still detonates.
    always_comb begin
        newStrikes = '0;
        for (int i = 0; i < N_MOD; i++) begin
            newStrikes = newStrikes + 8'(mod_failed[i]);
        end
        strikeSum = 8'(strikes_q) + newStrikes;
    end

    // Round sequencing: next state plus the next value of every counter/latch.
    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        strikes_d  = strikes_q;
        timeLeft_d = timeLeft_q;
        pulse_d    = 1'b0;
        fault_d    = fault_q;
        presc_d    = presc_q;
        actCnt_d   = actCnt_q;
        detCnt_d   = detCnt_q;
        solved_d   = solved_q;

        case (state_q)
            IDLE: begin
                if (startRise) begin
                    rnd_d      = rnd_in;
                    strikes_d  = '0;
                    timeLeft_d = TIME_INIT;
                    solved_d   = '0;
                    actCnt_d   = '0;
                    state_d    = ACTIVATING;
                end
            end

            ACTIVATING: begin
                actCnt_d = actCnt_q + AW'(1);
                if (&mod_activated) begin
                    presc_d = '0;
                    state_d = ACTIVATED;
                end else if (actCnt_q == ACT_LAST) begin
                    fault_d = 1'b1;
                    state_d = MISSION_FAILED;
                end
            end

            ACTIVATED: begin
                solved_d = solved_q | mod_solved;

                if (newStrikes != 8'd0) begin
                    pulse_d   = 1'b1;
                    strikes_d = (strikeSum >= STRIKE_MAX_W) ? STRIKE_MAX : strikeSum[2:0];
                end

                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (timeLeft_q != 10'd0) begin
                        timeLeft_d = timeLeft_q - 10'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end

                if (strikeSum >= STRIKE_MAX_W) begin
                    detCnt_d = '0;
                    state_d  = DETONATING;
                end else if (timeLeft_q == 10'd0) begin
                    detCnt_d = '0;
                    state_d  = DETONATING;
                end else if (&solved_q) begin
                    state_d = MISSION_SUCCESSED;
                end
            end

            DETONATING: begin
                if (detCnt_q == DET_LAST) begin
                    state_d = MISSION_FAILED;
                end else begin
                    detCnt_d = detCnt_q + DW'(1);
                end
            end

            MISSION_FAILED, MISSION_SUCCESSED: begin
                if (startRise) begin
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wipes out any partial round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            rnd_q      <= '0;
            strikes_q  <= '0;
            timeLeft_q <= TIME_INIT;
            pulse_q    <= 1'b0;
            fault_q    <= 1'b0;
            presc_q    <= '0;
            actCnt_q   <= '0;
            detCnt_q   <= '0;
            solved_q   <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            rnd_q      <= rnd_d;
            strikes_q  <= strikes_d;
            timeLeft_q <= timeLeft_d;
            pulse_q    <= pulse_d;
            fault_q    <= fault_d;
            presc_q    <= presc_d;
            actCnt_q   <= actCnt_d;
            detCnt_q   <= detCnt_d;
            solved_q   <= solved_d;
        end
    end

    assign current_state = state_q;
    assign rnd           = rnd_q;
    assign strikes       = strikes_q;
    assign time_left     = timeLeft_q;
    assign strike_pulse  = pulse_q;
    assign act_fault     = fault_q;

endmodule

// File: tb/tb_bomb_center_controller.sv
// Directed bench for the bomb center controller with shortened timing
// (4-cycle seconds, 10 s countdown, 16-cycle activation window, 8-cycle detonation).

module tb_bomb_center_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] rnd_in;
    logic [3:0]  mod_activated;
    logic [3:0]  mod_failed;
    logic [3:0]  mod_solved;
    logic [2:0]  current_state;
    logic [31:0] rnd;
    logic [2:0]  strikes;
    logic [9:0]  time_left;
    logic        strike_pulse;
    logic        act_fault;

    int compared;
    int mismatched;

    bomb_center_controller #(
        .N_MOD(4), .MAX_STRIKES(3), .TICK_DIV(4), .TIME_SEC(10),
        .ACT_TIMEOUT(16), .DET_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rnd_in(rnd_in),
        .mod_activated(mod_activated), .mod_failed(mod_failed), .mod_solved(mod_solved),
        .current_state(current_state), .rnd(rnd), .strikes(strikes),
        .time_left(time_left), .strike_pulse(strike_pulse), .act_fault(act_fault)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with all inputs idle.
    task automatic doReset();
        rst = 1'b0;
        start = 1'b0;
        rnd_in = '0;
        mod_activated = '0;
        mod_failed = '0;
        mod_solved = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Start a round, idle 3 cycles in ACTIVATING, then report all modules activated.
    task automatic goActivated(input logic [31:0] seed);
        rnd_in = seed;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        compared++;
        if (current_state !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL enter_activating: got %0d expected 1", current_state);
        end
        repeat (3) stepCycle();
        mod_activated = 4'b1111;
        stepCycle();
        compared++;
        if (current_state !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL enter_activated: got %0d expected 2", current_state);
        end
        compared++;
        if (rnd !== seed) begin
            mismatched++;
            $display("[TB] FAIL seed_latched: got %08h expected %08h", rnd, seed);
        end
    endtask

    task automatic test_reset();
        doReset();
        compared++;
        if (current_state !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %0d expected 0", current_state);
        end
        compared++;
        if (rnd !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_rnd: got %08h expected 0", rnd);
        end
        compared++;
        if (strikes !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_strikes: got %0d expected 0", strikes);
        end
        compared++;
        if (time_left !== 10'd10) begin
            mismatched++;
            $display("[TB] FAIL reset_time: got %0d expected 10", time_left);
        end
        compared++;
        if (strike_pulse !== 1'b0 || act_fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b%b expected 00", strike_pulse, act_fault);
        end
    endtask

    task automatic test_normal_round();
        doReset();
        goActivated(32'hA5A5_1234);
        for (int b = 0; b < 4; b++) begin
            mod_solved = 4'b0001 << b;
            stepCycle();
            stepCycle();
            mod_solved = 4'b0000;
            if (b == 1) begin
                compared++;
                if (time_left !== 10'd9 || current_state !== 3'd2) begin
                    mismatched++;
                    $display("[TB] FAIL normal_mid: got time %0d state %0d expected 9 / 2", time_left, current_state);
                end
            end
        end
        compared++;
        if (current_state !== 3'd5) begin
            mismatched++;
            $display("[TB] FAIL normal_success: got %0d expected 5", current_state);
        end
        repeat (3) stepCycle();
        compared++;
        if (current_state !== 3'd5 || time_left !== 10'd8) begin
            mismatched++;
            $display("[TB] FAIL normal_hold: got state %0d time %0d expected 5 / 8", current_state, time_left);
        end
        compared++;
        if (rnd !== 32'hA5A5_1234) begin
            mismatched++;
            $display("[TB] FAIL normal_rnd_hold: got %08h expected a5a51234", rnd);
        end
    endtask

    task automatic test_strikes();
        int pulses;
        pulses = 0;
        doReset();
        goActivated(32'h0000_BEEF);
        mod_failed = 4'b0001;
        stepCycle();
        mod_failed = 4'b0000;
        pulses += int'(strike_pulse);
        compared++;
        if (strikes !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL strike_one: got %0d expected 1", strikes);
        end
        repeat (2) begin
            stepCycle();
            pulses += int'(strike_pulse);
        end
        mod_failed = 4'b0110;
        stepCycle();
        mod_failed = 4'b0000;
        pulses += int'(strike_pulse);
        compared++;
        if (strikes !== 3'd3 || current_state !== 3'd3) begin
            mismatched++;
            $display("[TB] FAIL strike_three: got strikes %0d state %0d expected 3 / 3", strikes, current_state);
        end
        repeat (7) begin
            stepCycle();
            pulses += int'(strike_pulse);
        end
        compared++;
        if (current_state !== 3'd3) begin
            mismatched++;
            $display("[TB] FAIL det_length: got %0d expected 3", current_state);
        end
        stepCycle();
        pulses += int'(strike_pulse);
        compared++;
        if (current_state !== 3'd4) begin
            mismatched++;
            $display("[TB] FAIL det_to_failed: got %0d expected 4", current_state);
        end
        compared++;
        if (pulses !== 2) begin
            mismatched++;
            $display("[TB] FAIL strike_pulse_count: got %0d expected 2", pulses);
        end
        compared++;
        if (time_left !== 10'd9) begin
            mismatched++;
            $display("[TB] FAIL det_time_frozen: got %0d expected 9", time_left);
        end
    endtask

    task automatic test_timeout();
        doReset();
        goActivated(32'h1357_9BDF);
        for (int k = 1; k <= 40; k++) begin
            stepCycle();
            compared++;
            if (time_left !== 10'(10 - k / 4) || current_state !== 3'd2) begin
                mismatched++;
                $display("[TB] FAIL countdown_k%0d: got time %0d state %0d expected %0d / 2",
                         k, time_left, current_state, 10 - k / 4);
            end
        end
        stepCycle();
        compared++;
        if (current_state !== 3'd3 || time_left !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL timeout_det: got state %0d time %0d expected 3 / 0", current_state, time_left);
        end
        repeat (8) stepCycle();
        compared++;
        if (current_state !== 3'd4 || time_left !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL timeout_failed: got state %0d time %0d expected 4 / 0", current_state, time_left);
        end
    endtask

    task automatic test_act_fault();
        doReset();
        mod_activated = 4'b0111;
        rnd_in = 32'h0BAD_F00D;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        repeat (15) stepCycle();
        compared++;
        if (current_state !== 3'd1 || act_fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL act_window: got state %0d fault %b expected 1 / 0", current_state, act_fault);
        end
        stepCycle();
        compared++;
        if (current_state !== 3'd4 || act_fault !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL act_timeout: got state %0d fault %b expected 4 / 1", current_state, act_fault);
        end
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        compared++;
        if (current_state !== 3'd0 || act_fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL act_restart: got state %0d fault %b expected 0 / 0", current_state, act_fault);
        end
    endtask

    task automatic test_simultaneous();
        doReset();
        goActivated(32'h2468_ACE0);
        mod_failed = 4'b0011;
        stepCycle();
        mod_failed = 4'b0000;
        mod_solved = 4'b0111;
        stepCycle();
        compared++;
        if (strikes !== 3'd2 || current_state !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL simul_pre: got strikes %0d state %0d expected 2 / 2", strikes, current_state);
        end
        mod_solved = 4'b1111;
        mod_failed = 4'b1000;
        stepCycle();
        mod_failed = 4'b0000;
        mod_solved = 4'b0000;
        compared++;
        if (current_state !== 3'd3 || strikes !== 3'd3) begin
            mismatched++;
            $display("[TB] FAIL simul_detonate: got state %0d strikes %0d expected 3 / 3", current_state, strikes);
        end
        stepCycle();
        compared++;
        if (current_state !== 3'd3) begin
            mismatched++;
            $display("[TB] FAIL simul_not_success: got %0d expected 3", current_state);
        end
    endtask

    task automatic test_reset_mid_round();
        doReset();
        goActivated(32'hCAFE_0001);
        mod_failed = 4'b0011;
        stepCycle();
        mod_failed = 4'b0000;
        repeat (15) stepCycle();
        compared++;
        if (strikes !== 3'd2 || time_left !== 10'd6 || current_state !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL mid_setup: got strikes %0d time %0d state %0d expected 2 / 6 / 2",
                     strikes, time_left, current_state);
        end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (current_state !== 3'd0 || strikes !== 3'd0 || time_left !== 10'd10 || rnd !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got state %0d strikes %0d time %0d rnd %08h expected 0 / 0 / 10 / 0",
                     current_state, strikes, time_left, rnd);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        stepCycle();
        compared++;
        if (current_state !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_idle: got %0d expected 0", current_state);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b0;
        start = 1'b0;
        rnd_in = '0;
        mod_activated = '0;
        mod_failed = '0;
        mod_solved = '0;
        test_reset();
        test_normal_round();
        test_strikes();
        test_timeout();
        test_act_fault();
        test_simultaneous();
        test_reset_mid_round();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bomb_center_controller.md
Name: bomb_center_controller

Overview:
- Top-level game sequencer for the bomb board.
- Drives the shared 3-bit current_state bus into every puzzle module and latches one random seed per round that all modules consume.
- Handshakes module activation, aggregates per-module strike pulses and solved levels, and runs the countdown timer.
- Decides success, detonation or failure for the whole bomb.

Parameters:
N_MOD, 4, number of puzzle modules attached.
MAX_STRIKES, 3, strike count that ends the mission (1..7).
TICK_DIV, 50000000, clk cycles per countdown second.
TIME_SEC, 300, initial countdown in seconds (fits 10 bits).
ACT_TIMEOUT, 1024, cycles allowed in ACTIVATING for all modules to report activated.
DET_CYCLES, 100000000, cycles spent in DETONATING before MISSION_FAILED.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-low reset.
start  in  1  debounced start button, level; only its rising edge is used.
rnd_in  in  32  free-running random source.
mod_activated  in  N_MOD  per-module activated level.
mod_failed  in  N_MOD  per-module one-cycle strike pulse.
mod_solved  in  N_MOD  per-module solved level.
current_state  out  3  IDLE=0, ACTIVATING=1, ACTIVATED=2, DETONATING=3, MISSION_FAILED=4, MISSION_SUCCESSED=5.
rnd  out  32  seed latched for the current round.
strikes  out  3  accumulated strikes, saturating at MAX_STRIKES.
time_left  out  10  remaining seconds.
strike_pulse  out  1  one-cycle pulse for each cycle in which at least one strike is counted.
act_fault  out  1  sticky; set when ACTIVATING times out.

Behaviour:
- Reset values (asynchronous on rst=0):
  - current_state=IDLE, rnd=0, strikes=0, time_left=TIME_SEC.
  - strike_pulse=0, act_fault=0.
  - Prescaler, activation counter, detonation counter and solved latches all 0.
- start_rise = start & ~start_q, where start_q is a registered copy of start with reset value 0.
- IDLE:
  - On start_rise, latch rnd<=rnd_in, clear strikes, load time_left=TIME_SEC, clear the solved latches, then go to ACTIVATING.
- ACTIVATING:
  - The activation counter increments every cycle.
  - If &mod_activated, go to ACTIVATED and clear the prescaler.
  - Otherwise, if the counter reaches ACT_TIMEOUT-1, set act_fault and go to MISSION_FAILED.
  - Strike pulses are ignored in this state.
- ACTIVATED:
  - Solved latches: solved_l <= solved_l | mod_solved (sticky until the next round).
  - Strike counting:
    - new = popcount(mod_failed) in this cycle.
    - strikes <= min(strikes+new, MAX_STRIKES).
    - strike_pulse=1 when new!=0.
  - Prescaler:
    - Counts 0..TICK_DIV-1.
    - On wrap, time_left decrements by 1 and never underflows below 0.
  - Priority, evaluated on the registered values in the next cycle:
    - First: if strikes+new >= MAX_STRIKES, go to DETONATING.
    - Else if time_left==0, go to DETONATING.
    - Else if &solved_l, go to MISSION_SUCCESSED.
    - A final strike and a final solve in the same cycle therefore detonate.
- DETONATING:
  - The counter runs for DET_CYCLES cycles, then the block goes to MISSION_FAILED.
  - The timer is frozen and inputs are ignored.
- MISSION_FAILED and MISSION_SUCCESSED:
  - Terminal; all counters are frozen and outputs hold.
  - On start_rise, go to IDLE. act_fault clears on this transition.
- Invalid state encodings (6, 7) recover to IDLE on the next clk.
- Reset mid-operation returns immediately to the reset values. No partial round survives a reset.
- rnd is stable for the whole round and changes only on the IDLE->ACTIVATING edge.
- Outputs are all registered, giving one cycle of latency from the causing input.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, TIME_SEC=10, MAX_STRIKES=3, ACT_TIMEOUT=16, DET_CYCLES=8, N_MOD=4.
1. Normal round: rnd_in=0xA5A5_1234 and pulse start; raise mod_activated=4'b1111 at cycle 5 -> current_state goes 1 then 2, rnd=0xA5A5_1234; then assert mod_solved bits one at a time, each dropped after 2 cycles -> state=5 once the last latch sets; time_left is decremented every 4 cycles while ACTIVATED.
2. Strikes: in ACTIVATED, pulse mod_failed=4'b0001, then later 4'b0110 -> strikes 1 then 3; strike_pulse is 1 for exactly 2 cycles total; state goes to 3, then after 8 cycles to 4.
3. Timeout: no strikes and no solves -> time_left counts 10 down to 0 over 40 cycles, holds at 0, state goes to 3 then 4; time_left never wraps to 1023.
4. Activation fault: start, mod_activated stays 4'b0111 -> state=4 after 16 cycles in ACTIVATING, act_fault=1; start_rise -> state=0 and act_fault=0.
5. Simultaneous events: strikes=2, then in one cycle the fourth solve arrives together with mod_failed=4'b1000 -> state=3, not 5.
6. Reset mid-round: pull rst low during ACTIVATED with strikes=2 and time_left=6 -> state=0, strikes=0, time_left=10, rnd=0 asynchronously, without waiting for a clock edge.
